// File: rtl/pre_if_stage.sv
// Pre-fetch stage: owns the fetch PC, picks the next PC, issues inst-sram address requests
// and hands accepted fetches (or excepting PCs) to if_stage; tracks stale fetches to drop.
module pre_if_stage #(
  parameter logic [31:0]  RESET_PC = 32'hbfc00000,
  parameter int unsigned  BUS_WD   = 35
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_allowin,
  output logic              ps_to_fs_valid,
  output logic [BUS_WD-1:0] ps_to_fs_bus,
  input  logic              br_stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              slot_issued,
  input  logic              handle_exc,
  input  logic              handle_eret,
  input  logic              pipe_flush,
  input  logic [31:0]       ex_entry,
  input  logic [31:0]       epc,
  input  logic [31:0]       refetch_pc,
  input  logic              tlb_miss,
  input  logic              tlb_invalid,
  output logic              inst_sram_req,
  output logic [31:0]       inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  output logic              ps_drop
);

  localparam int unsigned CNT_W = 2;

  logic [31:0]      ps_pc_q, ps_pc_d;
  logic             pend_q, pend_d;
  logic             redir_vld_q, redir_vld_d;
  logic [31:0]      redir_buf_q, redir_buf_d;
  logic             br_vld_q, br_vld_d;
  logic [31:0]      br_buf_q, br_buf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic        pc_adel, ps_ex;
  logic        wb_redir, br_redir, redir_now;
  logic [31:0] wb_tgt, redir_tgt, seq_tgt;
  logic        issue_ok, req, acc, stale_acc, fetch_handoff, exc_handoff, drop_dec;

  // Request/hand-off decode from the current PC and this cycle's redirects
  always_comb begin
    pc_adel   = |ps_pc_q[1:0];
    ps_ex     = pc_adel | tlb_miss | tlb_invalid;
    wb_redir  = handle_exc | handle_eret | pipe_flush;
    br_redir  = br_taken & slot_issued;
    redir_now = wb_redir | br_redir;
    if (handle_exc)       wb_tgt = ex_entry;
    else if (handle_eret) wb_tgt = epc;
    else                  wb_tgt = refetch_pc;
    redir_tgt = wb_redir ? wb_tgt : br_target;
    // A taken branch whose slot is still ours: the slot goes out first, then the target
    if (br_vld_q)                      seq_tgt = br_buf_q;
    else if (br_taken && !slot_issued) seq_tgt = br_target;
    else                               seq_tgt = ps_pc_q + 32'd4;
    issue_ok      = !ps_ex && fs_allowin && !(br_stall && slot_issued) && (drop_cnt_q != 2'd3);
    req           = !reset && (pend_q || issue_ok);
    acc           = req && inst_sram_addr_ok;
    stale_acc     = acc && (redir_vld_q || redir_now);
    fetch_handoff = acc && !stale_acc;
    exc_handoff   = !reset && !req && ps_ex && fs_allowin && !redir_now;
    drop_dec      = inst_sram_data_ok && (drop_cnt_q != '0);
  end

  // Next-state logic for PC, pending request, redirect/branch buffers and drop counter
  always_comb begin
    ps_pc_d     = ps_pc_q;
    pend_d      = req && !inst_sram_addr_ok;
    redir_vld_d = redir_vld_q;
    redir_buf_d = redir_buf_q;
    br_vld_d    = br_vld_q;
    br_buf_d    = br_buf_q;
    drop_cnt_d  = drop_cnt_q + CNT_W'(stale_acc) - CNT_W'(drop_dec);

    if (req && !inst_sram_addr_ok) begin
      // Address must stay put; remember where to go once the stale request is accepted
      if (wb_redir) begin
        redir_vld_d = 1'b1;
        redir_buf_d = wb_tgt;
      end else if (br_redir && !redir_vld_q) begin
        redir_vld_d = 1'b1;
        redir_buf_d = br_target;
      end
    end else if (acc) begin
      redir_vld_d = 1'b0;
      if (redir_now)        ps_pc_d = redir_tgt;
      else if (redir_vld_q) ps_pc_d = redir_buf_q;
      else                  ps_pc_d = seq_tgt;
    end else if (redir_now) begin
      ps_pc_d = redir_tgt;
    end

    if (wb_redir || fetch_handoff) begin
      br_vld_d = 1'b0;
    end else if (br_taken && !slot_issued) begin
      br_vld_d = 1'b1;
      br_buf_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_pc_q     <= RESET_PC;
      pend_q      <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_buf_q <= '0;
      br_vld_q    <= 1'b0;
      br_buf_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      ps_pc_q     <= ps_pc_d;
      pend_q      <= pend_d;
      redir_vld_q <= redir_vld_d;
      redir_buf_q <= redir_buf_d;
      br_vld_q    <= br_vld_d;
      br_buf_q    <= br_buf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign inst_sram_req  = req;
  assign inst_sram_addr = ps_pc_q;
  assign ps_to_fs_valid = fetch_handoff || exc_handoff;
  assign ps_to_fs_bus   = BUS_WD'({pc_adel, tlb_miss, tlb_invalid, ps_pc_q});
  assign ps_drop        = (drop_cnt_q != '0);

endmodule

// File: tb/tb_pre_if_stage.sv
// Bench for pre_if_stage: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the fetch front end.
module tb_pre_if_stage;

  logic        clk, reset, fs_allowin;
  logic        ps_to_fs_valid;
  logic [34:0] ps_to_fs_bus;
  logic        br_stall, br_taken, slot_issued;
  logic [31:0] br_target;
  logic        handle_exc, handle_eret, pipe_flush;
  logic [31:0] ex_entry, epc, refetch_pc;
  logic        tlb_miss, tlb_invalid;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic        ps_drop;

  pre_if_stage dut (
    .clk(clk), .reset(reset), .fs_allowin(fs_allowin),
    .ps_to_fs_valid(ps_to_fs_valid), .ps_to_fs_bus(ps_to_fs_bus),
    .br_stall(br_stall), .br_taken(br_taken), .br_target(br_target),
    .slot_issued(slot_issued),
    .handle_exc(handle_exc), .handle_eret(handle_eret), .pipe_flush(pipe_flush),
    .ex_entry(ex_entry), .epc(epc), .refetch_pc(refetch_pc),
    .tlb_miss(tlb_miss), .tlb_invalid(tlb_invalid),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .ps_drop(ps_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: fetch PC, an outstanding unaccepted request, the PC to resume at
  // after a stale request, a branch target waiting behind its delay slot, stale count.
  logic [31:0] m_pc;
  bit          m_waiting;
  bit          m_resume_vld;
  logic [31:0] m_resume_pc;
  bit          m_slot_vld;
  logic [31:0] m_slot_tgt;
  int          m_stale_cnt;

  bit          e_req, e_accept, e_valid, e_drop;
  logic [34:0] e_bus;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_target();
    if (handle_exc)  return ex_entry;
    if (handle_eret) return epc;
    return refetch_pc;
  endfunction

  // Expected outputs for this cycle, then compare against the DUT
  task automatic model_check();
    bit exc, redirect;
    exc      = (m_pc[1:0] != 2'b00) || tlb_miss || tlb_invalid;
    redirect = handle_exc || handle_eret || pipe_flush || (br_taken && slot_issued);
    if (reset)          e_req = 0;
    else if (m_waiting) e_req = 1;
    else                e_req = !exc && fs_allowin && !(br_stall && slot_issued) && (m_stale_cnt < 3);
    e_accept = e_req && inst_sram_addr_ok;
    e_valid  = !reset && !redirect &&
               ((e_accept && !m_resume_vld) || (!e_req && exc && fs_allowin));
    e_bus    = {(m_pc[1:0] != 2'b00), tlb_miss, tlb_invalid, m_pc};
    e_drop   = (m_stale_cnt != 0);
    chk("req", 64'(inst_sram_req), 64'(e_req));
    chk("valid", 64'(ps_to_fs_valid), 64'(e_valid));
    chk("ps_drop", 64'(ps_drop), 64'(e_drop));
    if (e_req)   chk("addr", 64'(inst_sram_addr), 64'(m_pc));
    if (e_valid) chk("bus", 64'(ps_to_fs_bus), 64'(e_bus));
  endtask

  // Advance the model by one clock using this cycle's inputs
  task automatic model_step();
    bit wb, brr, redirect;
    logic [31:0] tgt;
    int old_cnt;
    if (reset) begin
      m_pc = 32'hbfc00000; m_waiting = 0; m_resume_vld = 0; m_slot_vld = 0; m_stale_cnt = 0;
      return;
    end
    wb       = handle_exc || handle_eret || pipe_flush;
    brr      = br_taken && slot_issued;
    redirect = wb || brr;
    tgt      = wb ? wb_target() : br_target;
    old_cnt  = m_stale_cnt;
    if (e_req && !inst_sram_addr_ok) begin
      m_waiting = 1;
      if (wb) begin
        m_resume_vld = 1; m_resume_pc = tgt;
      end else if (brr && !m_resume_vld) begin
        m_resume_vld = 1; m_resume_pc = br_target;
      end
    end else begin
      m_waiting = 0;
      if (e_accept) begin
        if (redirect || m_resume_vld) begin
          m_stale_cnt++;
          m_pc = redirect ? tgt : m_resume_pc;
        end else if (m_slot_vld) m_pc = m_slot_tgt;
        else if (br_taken)       m_pc = br_target;
        else                     m_pc = m_pc + 32'd4;
        m_resume_vld = 0;
      end else if (redirect) m_pc = tgt;
    end
    if (inst_sram_data_ok && old_cnt > 0) m_stale_cnt--;
    if (wb || (e_valid && e_accept)) m_slot_vld = 0;
    else if (br_taken && !slot_issued) begin
      m_slot_vld = 1; m_slot_tgt = br_target;
    end
  endtask

  task automatic look();
    @(negedge clk);
    model_check();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    br_taken = 0; handle_exc = 0; handle_eret = 0; pipe_flush = 0; inst_sram_data_ok = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(15) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    reset = 1; fs_allowin = 0; br_stall = 0; br_taken = 0; br_target = '0; slot_issued = 1;
    handle_exc = 0; handle_eret = 0; pipe_flush = 0; ex_entry = '0; epc = '0; refetch_pc = '0;
    tlb_miss = 0; tlb_invalid = 0; inst_sram_addr_ok = 0; inst_sram_data_ok = 0;

    // Reset state
    step();
    look();
    chk("rst_req", 64'(inst_sram_req), 64'd0);
    chk("rst_valid", 64'(ps_to_fs_valid), 64'd0);
    chk("rst_drop", 64'(ps_drop), 64'd0);
    chk("rst_pc", 64'(inst_sram_addr), 64'h bfc00000);
    step();

    // Sequential fetch from the reset vector
    reset = 0; fs_allowin = 1; inst_sram_addr_ok = 1;
    look(); chk("seq0_addr", 64'(inst_sram_addr), 64'hbfc00000); chk("seq0_valid", 64'(ps_to_fs_valid), 64'd1); step();
    look(); chk("seq1_addr", 64'(inst_sram_addr), 64'hbfc00004); chk("seq1_valid", 64'(ps_to_fs_valid), 64'd1); step();
    look(); chk("seq2_addr", 64'(inst_sram_addr), 64'hbfc00008); chk("seq2_valid", 64'(ps_to_fs_valid), 64'd1); step();

    // Exception while a request waits for addr_ok
    inst_sram_addr_ok = 0;
    look(); chk("hold0_addr", 64'(inst_sram_addr), 64'hbfc0000c); step();
    handle_exc = 1; ex_entry = 32'hbfc00380;
    look(); chk("hold1_addr", 64'(inst_sram_addr), 64'hbfc0000c); step();
    look(); chk("hold2_addr", 64'(inst_sram_addr), 64'hbfc0000c); chk("hold2_req", 64'(inst_sram_req), 64'd1); step();
    inst_sram_addr_ok = 1;
    look(); chk("stale_valid", 64'(ps_to_fs_valid), 64'd0); chk("stale_addr", 64'(inst_sram_addr), 64'hbfc0000c); step();
    inst_sram_data_ok = 1;
    look(); chk("drop_set", 64'(ps_drop), 64'd1); chk("exc_addr", 64'(inst_sram_addr), 64'hbfc00380);
    chk("exc_valid", 64'(ps_to_fs_valid), 64'd1); step();
    look(); chk("drop_clr", 64'(ps_drop), 64'd0); step();

    // Taken branch whose delay slot is not yet issued
    fs_allowin = 0; handle_exc = 1; ex_entry = 32'h80000008;
    look(); chk("br_idle_req", 64'(inst_sram_req), 64'd0); step();
    fs_allowin = 1; inst_sram_addr_ok = 0; br_taken = 1; br_target = 32'h80001000; slot_issued = 0;
    look(); chk("slot_addr_wait", 64'(inst_sram_addr), 64'h80000008); step();
    inst_sram_addr_ok = 1; slot_issued = 0;
    look(); chk("slot_addr", 64'(inst_sram_addr), 64'h80000008); chk("slot_valid", 64'(ps_to_fs_valid), 64'd1); step();
    slot_issued = 1;
    look(); chk("tgt_addr", 64'(inst_sram_addr), 64'h80001000); chk("tgt_valid", 64'(ps_to_fs_valid), 64'd1); step();

    // Misaligned refetch PC: handed off as an exception, no request
    fs_allowin = 0; pipe_flush = 1; refetch_pc = 32'h80000002;
    look(); step();
    fs_allowin = 1;
    look(); chk("adel_req", 64'(inst_sram_req), 64'd0); chk("adel_valid", 64'(ps_to_fs_valid), 64'd1);
    chk("adel_bus", 64'(ps_to_fs_bus), 64'h4_8000_0002); step();
    look(); chk("adel_hold", 64'(ps_to_fs_bus), 64'h4_8000_0002); step();

    // TLB miss hand-off, then a same-cycle exception takes priority
    handle_eret = 1; epc = 32'h00400000;
    look(); chk("eret_valid", 64'(ps_to_fs_valid), 64'd0); step();
    tlb_miss = 1;
    look(); chk("tlb_req", 64'(inst_sram_req), 64'd0); chk("tlb_bus", 64'(ps_to_fs_bus), 64'h2_0040_0000);
    chk("tlb_valid", 64'(ps_to_fs_valid), 64'd1); step();
    handle_exc = 1; ex_entry = 32'hbfc00380;
    look(); chk("tlb_exc_valid", 64'(ps_to_fs_valid), 64'd0); step();
    tlb_miss = 0;
    look(); chk("after_tlb_addr", 64'(inst_sram_addr), 64'hbfc00380); chk("after_tlb_req", 64'(inst_sram_req), 64'd1); step();

    // Three stale acceptances fill the drop counter and block requests
    repeat (3) begin
      pipe_flush = 1; refetch_pc = 32'hbfc00000;
      look(); chk("stale3_valid", 64'(ps_to_fs_valid), 64'd0); step();
    end
    look(); chk("full_drop", 64'(ps_drop), 64'd1); chk("full_req", 64'(inst_sram_req), 64'd0); step();
    look(); chk("full_req2", 64'(inst_sram_req), 64'd0); step();
    inst_sram_data_ok = 1;
    look(); chk("full_req3", 64'(inst_sram_req), 64'd0); step();
    look(); chk("unblk_req", 64'(inst_sram_req), 64'd1); chk("unblk_addr", 64'(inst_sram_addr), 64'hbfc00000); step();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset             = ($urandom_range(499) == 0);
      fs_allowin        = ($urandom_range(7) != 0);
      inst_sram_addr_ok = ($urandom_range(3) != 0);
      inst_sram_data_ok = ($urandom_range(2) == 0);
      br_stall          = ($urandom_range(5) == 0);
      slot_issued       = $urandom_range(1) == 1;
      br_taken          = !br_stall && ($urandom_range(9) == 0);
      br_target         = rand_pc();
      handle_exc        = ($urandom_range(39) == 0);
      handle_eret       = ($urandom_range(49) == 0);
      pipe_flush        = ($urandom_range(39) == 0);
      ex_entry          = rand_pc();
      epc               = rand_pc();
      refetch_pc        = rand_pc();
      tlb_miss          = ($urandom_range(19) == 0);
      tlb_invalid       = ($urandom_range(24) == 0);
      look();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
